fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port among NUM_REQ producers
// Define FIFO_ARB_BURST_EN to let a grant run for up to MAX_BURST words; otherwise one word per grant.

module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic [FIFO_WIDTH-1:0]         fifo_din,
  output logic                          fifo_wen,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   last_owner;
  logic [IDX_W-1:0]   nxt_owner;
  logic [IDX_W:0]     srch_base;
  logic [IDX_W:0]     offset;
  logic [IDX_W:0]     cand;
  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [NUM_REQ-1:0] rot_valid;
  logic               own;
  logic               owner_valid;
  logic               last_beat;
  logic               release_now;

  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 256) begin : g_param_check
    $error("fifo_wr_arbiter: parameter out of range");
  end

  // Rotate the request vector so the search always starts at last_owner+1, then map back.
  always_comb begin
    srch_base = (last_owner == IDX_W'(NUM_REQ-1)) ? '0 : {1'b0, last_owner} + (IDX_W+1)'(1);
    dbl_valid = {req_valid, req_valid};
    rot_valid = dbl_valid[srch_base +: NUM_REQ];
    offset    = '0;
    for (int j = NUM_REQ-1; j >= 0; j--) begin
      if (rot_valid[j]) offset = (IDX_W+1)'(j);
    end
    cand = srch_base + offset;
    if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
    nxt_owner = cand[IDX_W-1:0];
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int BCW = $clog2(MAX_BURST) + 1;
  logic [BCW-1:0] burst_cnt;
  assign last_beat = (burst_cnt == BCW'(MAX_BURST - 1));
`else
  assign last_beat = 1'b1;
`endif

  assign own         = (state == S_OWN);
  assign owner_valid = req_valid[owner];
  // Gating with rst_n keeps the reset cycle write-free even though grant is still registered.
  assign fifo_wen    = own && owner_valid && !fifo_full && rst_n;
  assign req_ready   = (own && !fifo_full && rst_n) ? grant : '0;
  assign fifo_din    = own ? req_data[owner*FIFO_WIDTH +: FIFO_WIDTH] : '0;
  assign release_now = !owner_valid || (fifo_wen && last_beat);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_REQ-1);
      grant      <= '0;
      busy       <= 1'b0;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            owner <= nxt_owner;
            grant <= NUM_REQ'(1) << nxt_owner;
            busy  <= 1'b1;
            state <= S_OWN;
`ifdef FIFO_ARB_BURST_EN
            burst_cnt <= '0;
`endif
          end
        end
        S_OWN: begin
`ifdef FIFO_ARB_BURST_EN
          if (fifo_wen) burst_cnt <= burst_cnt + BCW'(1);
`endif
          if (release_now) begin
            state      <= S_IDLE;
            last_owner <= owner;
            grant      <= '0;
            busy       <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
// Expected burst length follows FIFO_ARB_BURST_EN (8 when defined, 1 otherwise).

module tb_fifo_wr_arbiter;

`ifdef FIFO_ARB_BURST_EN
  localparam int B = 8;
`else
  localparam int B = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic [15:0] fifo_din;
  logic        fifo_wen;
  logic [3:0]  grant;
  logic        busy;

  fifo_wr_arbiter #(.FIFO_WIDTH(16), .NUM_REQ(4), .MAX_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_din(fifo_din),
    .fifo_wen(fifo_wen), .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          cnt [4];
  logic [15:0] nxt [4];
  logic [3:0]  s_grant, s_ready, s_valid, prev_grant;
  logic        s_wen, s_busy, s_full;
  logic [15:0] s_din;
  logic [15:0] wlog [$];
  logic [3:0]  gseq [$];
  int          gwords [$];
  int          gaps [$];
  int          idle_run;

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (cnt[i] > 0);
      req_data[i*16 +: 16] = nxt[i];
    end
  endtask

  task automatic clear_mon();
    wlog.delete(); gseq.delete(); gwords.delete(); gaps.delete();
    idle_run = 0; prev_grant = '0;
  endtask

  // One clock: sample the settled cycle, log it, then advance producers after the edge.
  task automatic step();
    #1;
    s_grant = grant; s_ready = req_ready; s_valid = req_valid;
    s_wen = fifo_wen; s_busy = busy; s_full = fifo_full; s_din = fifo_din;
    checks++;
    if (s_wen && s_full) begin
      errors++; $display("FAIL wen_while_full: wen=%b full=%b required wen=0", s_wen, s_full);
    end
    if (s_grant == 4'b0000) idle_run++;
    if (s_grant != 4'b0000 && prev_grant == 4'b0000) begin
      gseq.push_back(s_grant); gwords.push_back(0); gaps.push_back(idle_run); idle_run = 0;
    end
    if (s_wen) begin
      wlog.push_back(s_din);
      if (gwords.size() > 0) gwords[gwords.size()-1] += 1;
    end
    prev_grant = s_grant;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (s_ready[i] && s_valid[i]) begin
        cnt[i] = cnt[i] - 1; nxt[i] = nxt[i] + 16'd1;
      end
    end
    drive_inputs();
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    do begin step(); n++; end while (!(s_grant == 4'b0000 && s_valid == 4'b0000) && n < budget);
    checks++;
    if (!(s_grant == 4'b0000 && s_valid == 4'b0000)) begin
      errors++; $display("FAIL %s_timeout: still active after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; nxt[i] = '0; end
    drive_inputs();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++; if (s_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b required 0000", s_grant); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", s_busy); end
    checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b required 0000", s_ready); end
    checks++; if (s_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b required 0", s_wen); end
    checks++; if (s_din !== 16'h0000) begin errors++; $display("FAIL reset_din: got %h required 0000", s_din); end
  endtask

  task automatic test_single_producer();
    do_reset();
    cnt[0] = 10; nxt[0] = 16'h0100; drive_inputs();
    step();
    checks++; if (s_grant !== 4'b0000) begin errors++; $display("FAIL sp_arb_cycle_grant: got %b required 0000", s_grant); end
    step();
    checks++; if (s_grant !== 4'b0001) begin errors++; $display("FAIL sp_first_grant: got %b required 0001", s_grant); end
    checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL sp_first_busy: got %b required 1", s_busy); end
    checks++; if (s_wen !== 1'b1) begin errors++; $display("FAIL sp_first_wen: got %b required 1", s_wen); end
    checks++; if (s_din !== 16'h0100) begin errors++; $display("FAIL sp_first_din: got %h required 0100", s_din); end
    drain(80, "sp");
    checks++; if (wlog.size() != 10) begin errors++; $display("FAIL sp_write_count: got %0d required 10", wlog.size()); end
    for (int k = 0; k < 10 && k < wlog.size(); k++) begin
      checks++;
      if (wlog[k] !== 16'h0100 + 16'(k)) begin
        errors++; $display("FAIL sp_word%0d: got %h required %h", k, wlog[k], 16'h0100 + 16'(k));
      end
    end
    checks++; if (gseq.size() != (10 + B - 1) / B) begin errors++; $display("FAIL sp_grant_count: got %0d required %0d", gseq.size(), (10 + B - 1) / B); end
    checks++; if (gwords.size() < 2 || gwords[0] != B) begin errors++; $display("FAIL sp_first_burst_len: got %0d required %0d", (gwords.size() > 0) ? gwords[0] : -1, B); end
    checks++; if (gaps.size() < 2 || gaps[1] != 1) begin errors++; $display("FAIL sp_bubble: got %0d required 1", (gaps.size() > 1) ? gaps[1] : -1); end
  endtask

  task automatic test_round_robin();
    int n = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin cnt[i] = 100; nxt[i] = 16'h1000 * 16'(i + 1); end
    drive_inputs();
    while (gseq.size() < 9 && n < 300) begin step(); n++; end
    checks++; if (gseq.size() < 9) begin errors++; $display("FAIL rr_timeout: got %0d grants required 9", gseq.size()); end
    for (int k = 0; k < 8 && k + 1 < gseq.size(); k++) begin
      checks++;
      if (gseq[k] !== (4'b0001 << (k % 4))) begin
        errors++; $display("FAIL rr_grant%0d: got %b required %b", k, gseq[k], 4'b0001 << (k % 4));
      end
      checks++;
      if (gwords[k] != B) begin errors++; $display("FAIL rr_words%0d: got %0d required %0d", k, gwords[k], B); end
      checks++;
      if (gaps[k] != 1) begin errors++; $display("FAIL rr_gap%0d: got %0d required 1", k, gaps[k]); end
    end
  endtask

  task automatic test_full_stall();
    int pre;
    pre = (B > 3) ? 3 : 0;
    do_reset();
    cnt[2] = 20; nxt[2] = 16'h2000; drive_inputs();
    step();
    for (int k = 0; k < pre; k++) step();
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (s_wen !== 1'b0) begin errors++; $display("FAIL stall_wen%0d: got %b required 0", k, s_wen); end
      checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready%0d: got %b required 0000", k, s_ready); end
      checks++; if (s_grant !== 4'b0100) begin errors++; $display("FAIL stall_grant%0d: got %b required 0100", k, s_grant); end
    end
    fifo_full = 1'b0;
    drain(120, "stall");
    checks++; if (gwords.size() < 1 || gwords[0] != B) begin errors++; $display("FAIL stall_burst_len: got %0d required %0d", (gwords.size() > 0) ? gwords[0] : -1, B); end
    checks++; if (wlog.size() < B || wlog[B-1] !== 16'h2000 + 16'(B - 1)) begin errors++; $display("FAIL stall_last_word: required %h", 16'h2000 + 16'(B - 1)); end
  endtask

  task automatic test_wrap_priority();
    do_reset();
    cnt[1] = 1; nxt[1] = 16'h1000; drive_inputs();
    drain(20, "wrap_setup");
    cnt[0] = 2; nxt[0] = 16'h0A00; cnt[3] = 2; nxt[3] = 16'h3A00; drive_inputs();
    clear_mon();
    drain(60, "wrap");
    checks++; if (gseq.size() < 2 || gseq[0] !== 4'b1000) begin errors++; $display("FAIL wrap_first: got %b required 1000", (gseq.size() > 0) ? gseq[0] : 4'b0000); end
    checks++; if (gseq.size() < 2 || gseq[1] !== 4'b0001) begin errors++; $display("FAIL wrap_second: got %b required 0001", (gseq.size() > 1) ? gseq[1] : 4'b0000); end
    checks++; if (wlog.size() < 1 || wlog[0] !== 16'h3A00) begin errors++; $display("FAIL wrap_first_word: got %h required 3a00", (wlog.size() > 0) ? wlog[0] : 16'h0); end
  endtask

  task automatic test_drop_on_last();
    do_reset();
    cnt[1] = B; nxt[1] = 16'h1100; cnt[2] = 1; nxt[2] = 16'h2200; drive_inputs();
    drain(60, "drop");
    checks++; if (gseq.size() != 2) begin errors++; $display("FAIL drop_grant_count: got %0d required 2", gseq.size()); end
    checks++; if (gseq.size() < 1 || gseq[0] !== 4'b0010) begin errors++; $display("FAIL drop_first_owner: required 0010"); end
    checks++; if (gwords.size() < 1 || gwords[0] != B) begin errors++; $display("FAIL drop_burst_len: got %0d required %0d", (gwords.size() > 0) ? gwords[0] : -1, B); end
    checks++; if (gseq.size() < 2 || gseq[1] !== 4'b0100) begin errors++; $display("FAIL drop_next_owner: required 0100"); end
    checks++; if (gaps.size() < 2 || gaps[1] != 1) begin errors++; $display("FAIL drop_bubble: got %0d required 1", (gaps.size() > 1) ? gaps[1] : -1); end
    checks++; if (wlog.size() != B + 1 || wlog[B] !== 16'h2200) begin errors++; $display("FAIL drop_words: got %0d writes required %0d", wlog.size(), B + 1); end
  endtask

  task automatic test_mid_reset();
    int pre;
    int pre_writes;
    pre = (B > 3) ? 3 : 0;
    do_reset();
    cnt[1] = 1; nxt[1] = 16'h1000; drive_inputs();
    drain(20, "mr_setup");
    clear_mon();
    cnt[2] = 50; nxt[2] = 16'h2000; drive_inputs();
    step();
    for (int k = 0; k < pre; k++) step();
    rst_n = 1'b0;
    step();
    checks++; if (s_grant !== 4'b0100) begin errors++; $display("FAIL mr_owner_before: got %b required 0100", s_grant); end
    checks++; if (s_wen !== 1'b0) begin errors++; $display("FAIL mr_reset_cycle_wen: got %b required 0", s_wen); end
    checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL mr_reset_cycle_ready: got %b required 0000", s_ready); end
    pre_writes = wlog.size();
    checks++; if (pre_writes != pre) begin errors++; $display("FAIL mr_pre_writes: got %0d required %0d", pre_writes, pre); end
    rst_n = 1'b1;
    cnt[0] = 3; nxt[0] = 16'h0300; drive_inputs();
    clear_mon();
    step();
    checks++; if (s_grant !== 4'b0000) begin errors++; $display("FAIL mr_grant: got %b required 0000", s_grant); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL mr_busy: got %b required 0", s_busy); end
    checks++; if (s_wen !== 1'b0) begin errors++; $display("FAIL mr_wen: got %b required 0", s_wen); end
    checks++; if (s_din !== 16'h0000) begin errors++; $display("FAIL mr_din: got %h required 0000", s_din); end
    step();
    checks++; if (gseq.size() < 1 || gseq[0] !== 4'b0001) begin errors++; $display("FAIL mr_next_owner: got %b required 0001", (gseq.size() > 0) ? gseq[0] : 4'b0000); end
    checks++; if (wlog.size() < 1 || wlog[0] !== 16'h0300) begin errors++; $display("FAIL mr_next_word: got %h required 0300", (wlog.size() > 0) ? wlog[0] : 16'h0); end
  endtask

  initial begin
    rst_n = 1'b0; fifo_full = 1'b0; req_valid = '0; req_data = '0;
    test_reset();
    test_single_producer();
    test_round_robin();
    test_full_stall();
    test_wrap_priority();
    test_drop_on_last();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
